// File: rtl/triangle_sequencer.sv
// rtl/triangle_sequencer.sv - APU triangle channel period timer, 32-step sequencer and period register writes
module triangle_sequencer #(
    parameter int PERIOD_WIDTH = 11,
    parameter int MIN_PERIOD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       writeTimerLow,
    input  logic       writeTimerHigh,
    input  logic [6:0] linearCounterOut,
    input  logic [7:0] lengthCounterOut,
    output logic       setHaltFlag,
    output logic [3:0] sampleOut,
    output logic       stepTick
);

    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] timer;
    logic [4:0]              step;
    logic                    gate;
    logic                    timerZero;
    logic                    unusedData;

    // Only the low bits of the high write land in the period register.
    assign unusedData = ^dataIn[7:PERIOD_WIDTH-8];

    // Gate uses the registered period, so a write this cycle cannot open or close it.
    assign gate = (linearCounterOut != 7'd0) && (lengthCounterOut != 8'd0) &&
                  (period >= PERIOD_WIDTH'(MIN_PERIOD));
    assign timerZero = (timer == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period      <= '0;
            timer       <= '0;
            step        <= 5'd0;
            setHaltFlag <= 1'b0;
            stepTick    <= 1'b0;
        end else begin
            if (writeTimerLow) begin
                period[7:0] <= dataIn;
            end
            if (writeTimerHigh) begin
                period[PERIOD_WIDTH-1:8] <= dataIn[PERIOD_WIDTH-9:0];
            end
            // Reload samples the old period; writes never disturb timer or step phase.
            if (timerZero) begin
                timer <= period;
                if (gate) begin
                    step <= step + 5'd1;
                end
            end else begin
                timer <= timer - 1'b1;
            end
            stepTick    <= timerZero && gate;
            setHaltFlag <= writeTimerHigh;
        end
    end

    // First half ramps 15..0, second half ramps 0..15.
    always_comb begin
        sampleOut = step[4] ? step[3:0] : ~step[3:0];
    end

endmodule
